idu_pipe: RTL

Pipelined RV32I instruction decode stage between IFU and EXU. Accepts one instruction+PC per cycle over valid/ready. Decodes the full RV32I base set and writes registered decode bundles into an output FIFO of depth BUF_DEPTH. EXU drains the FIFO over its own valid/ready handshake. Supports flush for redirects and counts retired decodes.

---
 rtl/idu_pipe.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/idu_pipe.sv
// idu_pipe: RV32I decode stage, combinational decode of i_in_inst into a BUF_DEPTH-entry bundle FIFO.
// Latency: instruction accepted at edge N is at the FIFO head after edge N (out_valid at N+1 if empty).
// Backpressure: o_in_ready = !full; a same-cycle pop never frees a slot for that cycle's push.
module idu_pipe #(
    parameter int XLEN      = 32,
    parameter int BUF_DEPTH = 2,
    parameter bit RV32E     = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [31:0]     i_in_inst,
    input  logic [XLEN-1:0] i_in_pc,
    input  logic            i_flush,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_out_pc,
    output logic [4:0]      o_out_rs1,
    output logic [4:0]      o_out_rs2,
    output logic [4:0]      o_out_rd,
    output logic [31:0]     o_out_imm,
    output logic [3:0]      o_out_alu_op,
    output logic [1:0]      o_out_rdregsrc,
    output logic            o_out_alusrc1,
    output logic            o_out_alusrc2,
    output logic            o_out_jump,
    output logic            o_out_branch,
    output logic            o_out_mem_ren,
    output logic            o_out_mem_wen,
    output logic [2:0]      o_out_funct3,
    output logic            o_out_ebreak,
    output logic            o_out_illegal,
    output logic [31:0]     o_dec_cnt
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [31:0]     imm;
        logic [3:0]      alu_op;
        logic [1:0]      rdregsrc;
        logic            alusrc1;
        logic            alusrc2;
        logic            jump;
        logic            branch;
        logic            mem_ren;
        logic            mem_wen;
        logic [2:0]      funct3;
        logic            ebreak;
        logic            illegal;
    } dec_t;

    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL  = 7'b1101111,
                           OPC_JALR = 7'b1100111, OPC_BR   = 7'b1100011, OPC_LD   = 7'b0000011,
                           OPC_ST  = 7'b0100011, OPC_IMM   = 7'b0010011, OPC_OP   = 7'b0110011,
                           OPC_FENCE = 7'b0001111, OPC_SYS = 7'b1110011;
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;
    localparam logic [1:0] RS_ALU = 2'd0, RS_MEM = 2'd1, RS_SNPC = 2'd2, RS_NONE = 2'd3;
    localparam logic [31:0] INST_ECALL = 32'h0000_0073, INST_EBREAK = 32'h0010_0073;

    localparam int          PW       = $clog2(BUF_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(BUF_DEPTH);
    localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    // funct3 -> ALU op; alt selects SUB (R-type only) or SRA
    function automatic logic [3:0] f_alu(input logic [2:0] f3, input logic alt_sub, input logic alt_sra);
        case (f3)
            3'd0: f_alu = alt_sub ? ALU_SUB : ALU_ADD;
            3'd1: f_alu = ALU_SLL;
            3'd2: f_alu = ALU_SLT;
            3'd3: f_alu = ALU_SLTU;
            3'd4: f_alu = ALU_XOR;
            3'd5: f_alu = alt_sra ? ALU_SRA : ALU_SRL;
            3'd6: f_alu = ALU_OR;
            3'd7: f_alu = ALU_AND;
        endcase
    endfunction

    logic [6:0]  w_opc, w_f7;
    logic [2:0]  w_f3;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic        w_use_rs1, w_use_rs2, w_use_rd, w_bad;
    dec_t        w_dec, w_head;

    assign w_opc   = i_in_inst[6:0];
    assign w_f3    = i_in_inst[14:12];
    assign w_f7    = i_in_inst[31:25];
    assign w_imm_i = {{20{i_in_inst[31]}}, i_in_inst[31:20]};
    assign w_imm_s = {{20{i_in_inst[31]}}, i_in_inst[31:25], i_in_inst[11:7]};
    assign w_imm_b = {{19{i_in_inst[31]}}, i_in_inst[31], i_in_inst[7], i_in_inst[30:25], i_in_inst[11:8], 1'b0};
    assign w_imm_u = {i_in_inst[31:12], 12'b0};
    assign w_imm_j = {{11{i_in_inst[31]}}, i_in_inst[31], i_in_inst[19:12], i_in_inst[20], i_in_inst[30:21], 1'b0};

    // Combinational decode; illegal instructions collapse to a side-effect-free bundle
    always_comb begin
        w_dec          = '0;
        w_dec.pc       = i_in_pc;
        w_dec.rs1      = i_in_inst[19:15];
        w_dec.rs2      = i_in_inst[24:20];
        w_dec.rd       = i_in_inst[11:7];
        w_dec.funct3   = w_f3;
        w_dec.alu_op   = ALU_ADD;
        w_dec.rdregsrc = RS_NONE;
        w_use_rs1      = 1'b0;
        w_use_rs2      = 1'b0;
        w_use_rd       = 1'b0;
        w_bad          = 1'b0;
        case (w_opc)
            OPC_LUI: begin
                w_dec.imm = w_imm_u; w_dec.alusrc2 = 1'b1; w_dec.alu_op = ALU_PASSB;
                w_dec.rs1 = 5'd0; w_dec.rdregsrc = RS_ALU; w_use_rd = 1'b1;
            end
            OPC_AUIPC: begin
                w_dec.imm = w_imm_u; w_dec.alusrc1 = 1'b1; w_dec.alusrc2 = 1'b1;
                w_dec.rdregsrc = RS_ALU; w_use_rd = 1'b1;
            end
            OPC_JAL: begin
                w_dec.imm = w_imm_j; w_dec.alusrc1 = 1'b1; w_dec.alusrc2 = 1'b1;
                w_dec.jump = 1'b1; w_dec.rdregsrc = RS_SNPC; w_use_rd = 1'b1;
            end
            OPC_JALR: begin
                w_dec.imm = w_imm_i; w_dec.alusrc2 = 1'b1; w_dec.jump = 1'b1;
                w_dec.rdregsrc = RS_SNPC; w_use_rs1 = 1'b1; w_use_rd = 1'b1;
                w_bad = (w_f3 != 3'd0);
            end
            OPC_BR: begin
                w_dec.imm = w_imm_b; w_dec.alu_op = ALU_SUB; w_dec.branch = 1'b1; w_dec.rd = 5'd0;
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                w_bad = (w_f3 == 3'd2) || (w_f3 == 3'd3);
            end
            OPC_LD: begin
                w_dec.imm = w_imm_i; w_dec.alusrc2 = 1'b1; w_dec.mem_ren = 1'b1;
                w_dec.rdregsrc = RS_MEM; w_use_rs1 = 1'b1; w_use_rd = 1'b1;
                w_bad = (w_f3 == 3'd3) || (w_f3 >= 3'd6);
            end
            OPC_ST: begin
                w_dec.imm = w_imm_s; w_dec.alusrc2 = 1'b1; w_dec.mem_wen = 1'b1; w_dec.rd = 5'd0;
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                w_bad = (w_f3 >= 3'd3);
            end
            OPC_IMM: begin
                w_dec.imm = w_imm_i; w_dec.alusrc2 = 1'b1; w_dec.alu_op = f_alu(w_f3, 1'b0, i_in_inst[30]);
                w_dec.rdregsrc = RS_ALU; w_use_rs1 = 1'b1; w_use_rd = 1'b1;
                w_bad = ((w_f3 == 3'd1) && (w_f7 != 7'b0000000)) ||
                        ((w_f3 == 3'd5) && (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000));
            end
            OPC_OP: begin
                w_dec.alu_op = f_alu(w_f3, i_in_inst[30], i_in_inst[30]);
                w_dec.rdregsrc = RS_ALU; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_rd = 1'b1;
                w_bad = !((w_f7 == 7'b0000000) ||
                          ((w_f7 == 7'b0100000) && ((w_f3 == 3'd0) || (w_f3 == 3'd5))));
            end
            OPC_FENCE: w_bad = (w_f3 != 3'd0);
            OPC_SYS: begin
                if (i_in_inst == INST_EBREAK) begin
                    w_dec.ebreak = 1'b1; w_dec.rs1 = 5'd0; w_dec.rd = 5'd10;
                end else begin
                    w_bad = (i_in_inst != INST_ECALL);
                end
            end
            default: w_bad = 1'b1;
        endcase
        if (w_dec.rd == 5'd0) w_dec.rdregsrc = RS_NONE;
        if (RV32E && ((w_use_rs1 && w_dec.rs1[4]) || (w_use_rs2 && w_dec.rs2[4]) || (w_use_rd && w_dec.rd[4])))
            w_bad = 1'b1;
        if (w_bad) begin
            w_dec          = '0;
            w_dec.pc       = i_in_pc;
            w_dec.rs1      = i_in_inst[19:15];
            w_dec.rs2      = i_in_inst[24:20];
            w_dec.funct3   = w_f3;
            w_dec.rdregsrc = RS_NONE;
            w_dec.illegal  = 1'b1;
        end
    end

    dec_t          r_mem [BUF_DEPTH];
    logic [PW-1:0] r_wptr, r_rptr;
    logic [PW:0]   r_count;
    logic [31:0]   r_dec_cnt;
    logic          w_full, w_push, w_pop;

    assign w_full = (r_count == FULL_CNT);
    assign w_push = i_in_valid && !w_full && !i_flush;
    assign w_pop  = (r_count != '0) && i_out_ready && !i_flush;

    // FIFO pointers, occupancy and pop counter; reset beats flush, flush drops push and pop
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr <= '0; r_rptr <= '0; r_count <= '0; r_dec_cnt <= '0;
        end else if (i_flush) begin
            r_wptr <= '0; r_rptr <= '0; r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop) begin
                r_rptr    <= r_rptr + PTR_ONE;
                r_dec_cnt <= r_dec_cnt + 32'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Bundle storage; contents are don't-care until pushed, so no reset
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_push) r_mem[r_rptr == r_rptr ? r_wptr : r_wptr] <= w_dec;
    end

    // Head is the oldest entry, or an idle no-write bundle when empty
    always_comb begin
        w_head          = '0;
        w_head.rdregsrc = RS_NONE;
        if (r_count != '0) w_head = r_mem[r_rptr];
    end

    assign o_in_ready     = !w_full;
    assign o_out_valid    = (r_count != '0);
    assign o_out_pc       = w_head.pc;
    assign o_out_rs1      = w_head.rs1;
    assign o_out_rs2      = w_head.rs2;
    assign o_out_rd       = w_head.rd;
    assign o_out_imm      = w_head.imm;
    assign o_out_alu_op   = w_head.alu_op;
    assign o_out_rdregsrc = w_head.rdregsrc;
    assign o_out_alusrc1  = w_head.alusrc1;
    assign o_out_alusrc2  = w_head.alusrc2;
    assign o_out_jump     = w_head.jump;
    assign o_out_branch   = w_head.branch;
    assign o_out_mem_ren  = w_head.mem_ren;
    assign o_out_mem_wen  = w_head.mem_wen;
    assign o_out_funct3   = w_head.funct3;
    assign o_out_ebreak   = w_head.ebreak;
    assign o_out_illegal  = w_head.illegal;
    assign o_dec_cnt      = r_dec_cnt;

endmodule
